aes_job_sched: RTL
==================

Name: aes_job_sched

Overview:
- Job scheduler and memory-port arbiter for one HLS AES `workload` instance with ap_ctrl_hs control.
- Accepts queued block jobs (offset, tag) from a host.
- Launches the accelerator once per job with `data_offset` set, and waits for `ap_done`.
- A watchdog recovers a hung accelerator; the block then reports completion or timeout.
- Muxes the single data memory port between the host and the accelerator.

Parameters:
- AW, 4, memory address / data_offset width
- DW, 8, memory data width
- TAG_W, 4, job tag width
- QDEPTH, 4, job FIFO depth (power of 2, >=2)
- TIMEOUT, 1024, watchdog limit in RUN cycles (>=2)

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  synchronous active-low reset
- req_vld  in  1  host job valid
- req_rdy  out  1  FIFO not full
- req_offset  in  AW  job block offset
- req_tag  in  TAG_W  job tag
- cmp_vld  out  1  completion valid
- cmp_rdy  in  1  completion accept
- cmp_tag  out  TAG_W  tag of completed job
- cmp_timeout  out  1  1 = job aborted by watchdog
- acc_ap_start  out  1  accelerator start
- acc_ap_ready  in  1  accelerator accepted start
- acc_ap_done  in  1  accelerator finished
- acc_ap_idle  in  1  accelerator idle
- acc_rst  out  1  active-high reset to accelerator
- acc_data_offset  out  AW  offset for current job
- acc_addr  in  AW  accelerator memory address
- acc_ce  in  1  accelerator memory enable
- acc_we  in  1  accelerator memory write enable
- acc_d  in  DW  accelerator write data
- acc_q  out  DW  read data to accelerator
- host_addr  in  AW  host memory address
- host_ce  in  1  host memory enable
- host_we  in  1  host memory write enable
- host_d  in  DW  host write data
- host_q  out  DW  read data to host
- host_gnt  out  1  host owns memory port this cycle
- mem_addr  out  AW  memory address
- mem_ce  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_d  out  DW  memory write data
- mem_q  in  DW  memory read data (1-cycle latency)

Behaviour:
- Reset: every FSM state, counter and FIFO pointer is cleared while ap_rst_n=0 at an ap_clk edge.
  - State = IDLE, FIFO empty.
  - Outputs: cmp_vld=0, acc_ap_start=0, acc_data_offset=0, cmp_tag=0, cmp_timeout=0, watchdog=0.
  - acc_rst = !ap_rst_n || (state==FLUSH); it is combinational.
- Reset mid-job: the job is discarded and no completion is issued.

FIFO:
- Depth QDEPTH, entries {offset, tag}.
- req_rdy = (count != QDEPTH), derived from registered count.
- Push on req_vld && req_rdy.
- Pop only in IDLE; a push and a pop in the same cycle keep count unchanged.
- Pointers wrap modulo QDEPTH.

FSM:
- IDLE: if FIFO is non-empty && acc_ap_idle, pop the head into offset_r/tag_r, go to LAUNCH next cycle.
- LAUNCH:
  - acc_ap_start=1 and held until a cycle with acc_ap_ready=1.
  - acc_ap_ready && acc_ap_done in the same cycle -> REPORT (timeout=0).
  - acc_ap_ready alone -> RUN.
  - The watchdog counts here as well.
- RUN: acc_ap_start=0; watchdog increments each cycle.
  - acc_ap_done -> REPORT (timeout=0).
  - Else, if watchdog == TIMEOUT-1 -> FLUSH.
  - acc_ap_done wins if it coincides with the limit.
- FLUSH: acc_rst=1 for exactly 2 cycles (2-bit counter), then REPORT with timeout=1.
- REPORT: cmp_vld=1, with cmp_tag=tag_r and cmp_timeout=timeout_r stable until cmp_rdy; the handshake cycle returns to IDLE.
- Watchdog: cleared on entry to LAUNCH; width $clog2(TIMEOUT); it saturates and never wraps.
- acc_data_offset = offset_r, registered and stable from LAUNCH through REPORT.

Arbitration:
- Accelerator owns the memory port in LAUNCH and RUN; mem_* = acc_* there.
- Host owns it in IDLE and REPORT: host_gnt=1, mem_* = host_*.
- FLUSH: mem_ce=0, mem_we=0, host_gnt=0.
- Host accesses with host_gnt=0 are dropped; the host must hold its request until granted.
- host_q = acc_q = mem_q, unmuxed; each requester consumes only the reads it issued.

Decomposition:
- Package aes_sched_pkg holds:
  - the state enum (IDLE, LAUNCH, RUN, FLUSH, REPORT);
  - FLUSH_CYCLES=2;
  - the job entry struct {offset, tag}.
- One sub-module, aes_job_fifo: synchronous FIFO with count, parameterised by entry width and depth.

Test Plan:
- Single job: push offset=4, tag=3; accelerator gives ap_ready 1 cycle after start and ap_done 40 cycles later -> acc_data_offset=4 during the job, one completion with tag=3, timeout=0; host_gnt=0 throughout LAUNCH/RUN.
- Back-to-back queue: push 5 jobs (tags 0-4) with QDEPTH=4 and the accelerator stalled -> req_rdy=0 after 4 pushes; all 5 complete in tag order 0,1,2,3,4; no job is lost.
- Hung accelerator: ap_done is never asserted with TIMEOUT=16 -> FLUSH is entered 16 cycles after LAUNCH entry, acc_rst=1 for 2 cycles, then completion with timeout=1; the next job runs normally.
- Completion backpressure: cmp_rdy held 0 for 10 cycles -> cmp_vld, cmp_tag and cmp_timeout stay stable, no new launch occurs, and the host keeps the memory port (host_gnt=1).
- Coincidence: ap_ready and ap_done in the same cycle -> LAUNCH goes directly to REPORT; ap_done on the watchdog limit cycle -> timeout=0.
- Reset mid-RUN: ap_rst_n=0 for 1 cycle during RUN with 2 jobs queued -> state IDLE, FIFO empty, cmp_vld=0, acc_rst=1 during the reset cycle.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared types for the AES job scheduler: FSM states, flush length and the queued job entry.
package aes_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StRun,
    StFlush,
    StReport
  } sched_state_e;

  localparam int unsigned FlushCycles = 2;

  // Field widths of a queued job; the scheduler's AW / TAG_W must equal these.
  localparam int unsigned JobOffsetW = 4;
  localparam int unsigned JobTagW    = 4;

  typedef struct packed {
    logic [JobOffsetW-1:0] offset;
    logic [JobTagW-1:0]    tag;
  } job_t;

endpackage

// File: rtl/aes_job_fifo.sv
// Show-ahead synchronous FIFO with an occupancy counter; Depth must be a power of two.
module aes_job_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/aes_job_sched.sv
// Launches one ap_ctrl_hs AES accelerator per queued job, recovers hangs with a watchdog
// and shares the single data memory port between host and accelerator.
module aes_job_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned AW      = JobOffsetW,
  parameter int unsigned DW      = 8,
  parameter int unsigned TAG_W   = JobTagW,
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [AW-1:0]    req_offset,
  input  logic [TAG_W-1:0] req_tag,
  output logic             cmp_vld,
  input  logic             cmp_rdy,
  output logic [TAG_W-1:0] cmp_tag,
  output logic             cmp_timeout,
  output logic             acc_ap_start,
  input  logic             acc_ap_ready,
  input  logic             acc_ap_done,
  input  logic             acc_ap_idle,
  output logic             acc_rst,
  output logic [AW-1:0]    acc_data_offset,
  input  logic [AW-1:0]    acc_addr,
  input  logic             acc_ce,
  input  logic             acc_we,
  input  logic [DW-1:0]    acc_d,
  output logic [DW-1:0]    acc_q,
  input  logic [AW-1:0]    host_addr,
  input  logic             host_ce,
  input  logic             host_we,
  input  logic [DW-1:0]    host_d,
  output logic [DW-1:0]    host_q,
  output logic             host_gnt,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_ce,
  output logic             mem_we,
  output logic [DW-1:0]    mem_d,
  input  logic [DW-1:0]    mem_q
);

  localparam int unsigned    WdW     = $clog2(TIMEOUT);
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT - 1);

  sched_state_e   state_q, state_d;
  job_t           job_q, job_d;
  logic           timeout_q, timeout_d;
  logic [WdW-1:0] wdog_q, wdog_d, wdog_inc;
  logic [1:0]     flush_cnt_q, flush_cnt_d;

  job_t fifo_wdata, fifo_rdata;
  logic fifo_pop, fifo_full, fifo_empty;

  assign fifo_wdata = job_t'{offset: req_offset, tag: req_tag};

  aes_job_fifo #(
    .Width($bits(job_t)),
    .Depth(QDEPTH)
  ) u_fifo (
    .clk_i  (ap_clk),
    .rst_ni (ap_rst_n),
    .push_i (req_vld),
    .wdata_i(fifo_wdata),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Saturating increment: a long LAUNCH stall must not wrap the watchdog back to zero.
  assign wdog_inc = (wdog_q == WdLimit) ? wdog_q : wdog_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    timeout_d   = timeout_q;
    wdog_d      = wdog_q;
    flush_cnt_d = flush_cnt_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && acc_ap_idle) begin
          fifo_pop = 1'b1;
          job_d    = fifo_rdata;
          wdog_d   = '0;
          state_d  = StLaunch;
        end
      end
      StLaunch: begin
        wdog_d = wdog_inc;
        if (acc_ap_ready) begin
          if (acc_ap_done) begin
            timeout_d = 1'b0;
            state_d   = StReport;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        wdog_d = wdog_inc;
        if (acc_ap_done) begin
          timeout_d = 1'b0;
          state_d   = StReport;
        end else if (wdog_q == WdLimit) begin
          flush_cnt_d = '0;
          state_d     = StFlush;
        end
      end
      StFlush: begin
        if (flush_cnt_q == 2'(FlushCycles - 1)) begin
          timeout_d = 1'b1;
          state_d   = StReport;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      StReport: begin
        if (cmp_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= StIdle;
      job_q       <= '0;
      timeout_q   <= 1'b0;
      wdog_q      <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      timeout_q   <= timeout_d;
      wdog_q      <= wdog_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign req_rdy         = !fifo_full;
  assign cmp_vld         = (state_q == StReport);
  assign cmp_tag         = job_q.tag;
  assign cmp_timeout     = timeout_q;
  assign acc_ap_start    = (state_q == StLaunch);
  assign acc_data_offset = job_q.offset;
  assign acc_rst         = !ap_rst_n || (state_q == StFlush);

  // Read data fans out unmuxed; each side only consumes reads it issued itself.
  assign host_q = mem_q;
  assign acc_q  = mem_q;

  always_comb begin
    host_gnt = 1'b0;
    mem_addr = acc_addr;
    mem_ce   = 1'b0;
    mem_we   = 1'b0;
    mem_d    = acc_d;
    unique case (state_q)
      StLaunch, StRun: begin
        mem_ce = acc_ce;
        mem_we = acc_we;
      end
      StIdle, StReport: begin
        host_gnt = 1'b1;
        mem_addr = host_addr;
        mem_ce   = host_ce;
        mem_we   = host_we;
        mem_d    = host_d;
      end
      default: ;
    endcase
  end

endmodule
